// File: rtl/psdifir_mc_pkg.sv
// Shared types, width helpers and output rounding for the multi-channel FIR engine.
// Build option: define PSDIFIR_MC_SAT_EN to clamp outputs instead of wrapping them.
package psdifir_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ROUND,
        DONE
    } state_e;

    localparam int PIPE_LAT = 3;
    localparam int RW       = 128;

    function automatic int calcAw(input int ntaps);
        return $clog2(ntaps);
    endfunction

    function automatic int calcGw(input int ntaps, input int nlanes);
        return $clog2(ntaps / nlanes);
    endfunction

    function automatic int calcAccw(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    function automatic int calcChw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Round half-up, shift, then clamp or wrap into a dw-bit signed value (sign-extended to RW).
    function automatic logic signed [RW-1:0] roundShift(input logic signed [RW-1:0] acc,
                                                        input int shift, input int dw);
        logic signed [RW-1:0] y;
        logic signed [RW-1:0] lim;
        y = acc;
        if (shift > 0) begin
            y = y + (RW'(1) <<< (shift - 1));
        end
        y = y >>> shift;
`ifdef PSDIFIR_MC_SAT_EN
        lim = (RW'(1) <<< (dw - 1)) - RW'(1);
        if (y > lim) begin
            y = lim;
        end else if (y < (-lim - RW'(1))) begin
            y = -lim - RW'(1);
        end
`else
        lim = '0;
`endif
        y = (y <<< (RW - dw)) >>> (RW - dw);
        return y | (lim & '0);
    endfunction

endpackage

// File: rtl/psdifir_mac_lanes.sv
// NLANES parallel signed multipliers feeding a registered adder; fixed two-cycle latency.
module psdifir_mac_lanes #(
    parameter int  NLANES = 8,
    parameter int  DW     = 18,
    parameter int  CW     = 36,
    localparam int PW     = DW + CW,
    localparam int SW     = PW + $clog2(NLANES)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NLANES*DW-1:0]   samples_i,
    input  logic [NLANES*CW-1:0]   coefs_i,
    output logic signed [SW-1:0]   sum_o
);

    logic signed [PW-1:0] prod_d [NLANES];
    logic signed [PW-1:0] prod_q [NLANES];
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;

    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            prod_d[i] = PW'($signed(samples_i[i*DW +: DW])) * PW'($signed(coefs_i[i*CW +: CW]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NLANES; i++) begin
            sum_d = sum_d + SW'(prod_q[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NLANES; i++) begin
                prod_q[i] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int i = 0; i < NLANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/psdifir_mc_engine.sv
// Multi-channel FIR engine: one NLANES-wide MAC pipeline time-shared over NCH channels.
// Build option: PSDIFIR_MC_SAT_EN selects saturating output rounding (see psdifir_mc_pkg).
module psdifir_mc_engine
    import psdifir_mc_pkg::*;
#(
    parameter int  NCH       = 2,
    parameter int  NLANES    = 8,
    parameter int  NTAPS     = 2048,
    parameter int  DW        = 18,
    parameter int  CW        = 36,
    parameter int  OUT_SHIFT = 35,
    localparam int AW        = calcAw(NTAPS),
    localparam int GW        = calcGw(NTAPS, NLANES),
    localparam int ACCW      = calcAccw(DW, CW, NTAPS),
    localparam int CHW       = calcChw(NCH),
    localparam int LB        = $clog2(NLANES),
    localparam int SW        = DW + CW + LB
) (
    input  logic                  clockext100MHz,
    input  logic                  reset,
    input  logic                  datain_ready,
    input  logic [NCH*DW-1:0]     data_in,
    input  logic                  coef_shared,
    output logic                  cb_wen,
    output logic [AW-1:0]         cb_waddr,
    output logic [CHW-1:0]        cb_ch,
    output logic [AW-1:0]         cb_raddr,
    input  logic [NLANES*DW-1:0]  cb_rdata,
    output logic [CHW-1:0]        coef_ch,
    output logic [GW-1:0]         coef_addr,
    input  logic [NLANES*CW-1:0]  coef_rdata,
    output logic [NCH*DW-1:0]     data_out,
    output logic                  dataout_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [GW-1:0]  LAST_K    = GW'(NTAPS / NLANES - 1);
    localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
    localparam logic [1:0]     DRAIN_END = 2'(PIPE_LAT - 1);

    state_e                      state_q;
    logic [AW-1:0]               wptr_q;
    logic [AW-1:0]               base_q;
    logic [CHW-1:0]              ch_q;
    logic [GW-1:0]               k_q;
    logic [1:0]                  drain_q;
    logic                        shared_q;
    logic [PIPE_LAT-1:0]         vld_q;
    logic [PIPE_LAT-1:0]         first_q;
    logic signed [ACCW-1:0]      acc_q;
    logic signed [ACCW-1:0]      acc_d;
    logic [NCH-1:0][DW-1:0]      dataOut_q;
    logic                        busy_q;
    logic                        ready_q;
    logic                        overrun_q;
    logic signed [SW-1:0]        macSum;
    logic [DW-1:0]               yRound;
    logic                        issue;
    logic                        unusedDataIn;

    // Sample data goes straight from the codec to the buffer RAM; the engine only steers addresses.
    assign unusedDataIn = ^data_in;

    assign issue     = (state_q == ISSUE);
    assign cb_wen    = datain_ready & reset;
    assign cb_waddr  = wptr_q;
    assign cb_ch     = ch_q;
    assign cb_raddr  = base_q - (AW'(k_q) << LB);
    assign coef_ch   = shared_q ? '0 : ch_q;
    assign coef_addr = k_q;

    psdifir_mac_lanes #(
        .NLANES (NLANES),
        .DW     (DW),
        .CW     (CW)
    ) u_mac (
        .clk_i     (clockext100MHz),
        .rst_ni    (reset),
        .samples_i (cb_rdata),
        .coefs_i   (coef_rdata),
        .sum_o     (macSum)
    );

    always_comb begin
        acc_d = first_q[PIPE_LAT-1] ? ACCW'(macSum) : acc_q + ACCW'(macSum);
    end

    assign yRound = DW'(roundShift(RW'(acc_q), OUT_SHIFT, DW));

    // The write pointer keeps advancing on every strobe, even while a frame is in flight.
    always_ff @(posedge clockext100MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            base_q    <= '0;
            ch_q      <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            shared_q  <= 1'b0;
            vld_q     <= '0;
            first_q   <= '0;
            acc_q     <= '0;
            dataOut_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            vld_q   <= {vld_q[PIPE_LAT-2:0], issue};
            first_q <= {first_q[PIPE_LAT-2:0], issue && (k_q == '0)};
            if (datain_ready) begin
                wptr_q <= wptr_q + 1'b1;
                if (state_q != IDLE) begin
                    overrun_q <= 1'b1;
                end
            end
            if (vld_q[PIPE_LAT-1]) begin
                acc_q <= acc_d;
            end
            case (state_q)
                IDLE: begin
                    if (datain_ready) begin
                        base_q   <= wptr_q;
                        shared_q <= coef_shared;
                        ch_q     <= '0;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k_q == LAST_K) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_END) begin
                        state_q <= ROUND;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                ROUND: begin
                    dataOut_q[ch_q] <= yRound;
                    if (ch_q != LAST_CH) begin
                        ch_q    <= ch_q + 1'b1;
                        k_q     <= '0;
                        state_q <= ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out      = dataOut_q;
    assign dataout_ready = ready_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_psdifir_mc_engine.sv
// Scoreboard bench for psdifir_mc_engine with behavioural buffer/coefficient RAMs.
// Expected outputs follow PSDIFIR_MC_SAT_EN when it is defined for the build.
module tb_psdifir_mc_engine;

    localparam int NCH = 2, NLANES = 4, NTAPS = 16, DW = 18, CW = 36, OUT_SHIFT = 0;
    localparam int AW = 4, GW = 2, CHW = 1;
    localparam int FRAME_LAT = NCH * (NTAPS / NLANES + 4) + 1;
`ifdef PSDIFIR_MC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  datain_ready = 1'b0;
    logic [NCH*DW-1:0]     data_in = '0;
    logic                  coef_shared = 1'b0;
    logic                  cb_wen;
    logic [AW-1:0]         cb_waddr;
    logic [CHW-1:0]        cb_ch;
    logic [AW-1:0]         cb_raddr;
    logic [NLANES*DW-1:0]  cb_rdata = '0;
    logic [CHW-1:0]        coef_ch;
    logic [GW-1:0]         coef_addr;
    logic [NLANES*CW-1:0]  coef_rdata = '0;
    logic [NCH*DW-1:0]     data_out;
    logic                  dataout_ready;
    logic                  busy;
    logic                  overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames = 0;
    int badCoefCh = 0;
    bit sharedWatch = 1'b0;
    bit clearMem = 1'b0;

    logic [NCH*DW-1:0] expQ[$];
    int                startQ[$];
    logic [NCH*DW-1:0] expVal;
    int                startCyc;

    logic [DW-1:0] cbMem   [NCH][NTAPS];
    logic [CW-1:0] coefMem [NCH][NTAPS];

    psdifir_mc_engine #(
        .NCH(NCH), .NLANES(NLANES), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clockext100MHz (clk),
        .reset          (reset),
        .datain_ready   (datain_ready),
        .data_in        (data_in),
        .coef_shared    (coef_shared),
        .cb_wen         (cb_wen),
        .cb_waddr       (cb_waddr),
        .cb_ch          (cb_ch),
        .cb_raddr       (cb_raddr),
        .cb_rdata       (cb_rdata),
        .coef_ch        (coef_ch),
        .coef_addr      (coef_addr),
        .coef_rdata     (coef_rdata),
        .data_out       (data_out),
        .dataout_ready  (dataout_ready),
        .busy           (busy),
        .overrun        (overrun)
    );

    // 100 MHz clock and a free-running cycle count used for latency checks
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAMs with one-cycle read latency; newest sample and h[4k] sit in the top lane
    always @(posedge clk) begin
        if (clearMem) begin
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < NTAPS; t++)
                    cbMem[c][t] <= '0;
        end else if (cb_wen) begin
            for (int c = 0; c < NCH; c++)
                cbMem[c][cb_waddr] <= data_in[c*DW +: DW];
        end
        for (int j = 0; j < NLANES; j++) begin
            cb_rdata[j*DW +: DW]   <= cbMem[cb_ch][AW'(cb_raddr - AW'(NLANES - 1 - j))];
            coef_rdata[j*CW +: CW] <= coefMem[coef_ch][{coef_addr, 2'(NLANES - 1 - j)}];
        end
    end

    function automatic longint lane(input logic [NCH*DW-1:0] v, input int c);
        logic signed [DW-1:0] t;
        t = v[c*DW +: DW];
        return longint'(t);
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset && dataout_ready) begin
            frames++;
            checkOutput("readyHasExpectation", longint'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                expVal   = expQ.pop_front();
                startCyc = startQ.pop_front();
                checkOutput("dataOutCh0", lane(data_out, 0), lane(expVal, 0));
                checkOutput("dataOutCh1", lane(data_out, 1), lane(expVal, 1));
                checkOutput("frameLatency", cyc - startCyc, FRAME_LAT);
            end
        end
        if (reset && sharedWatch && busy && (coef_ch != '0)) badCoefCh++;
    end

    task automatic setCoefs(input int c, input bit impulse, input longint v);
        for (int t = 0; t < NTAPS; t++)
            coefMem[c][t] = impulse ? ((t == 0) ? CW'(1) : CW'(0)) : CW'(v);
    endtask

    task automatic applyStimulus(input int l, input int r, input bit expectFrame,
                                 input int expL, input int expR);
        @(posedge clk); #1;
        data_in = {DW'(r), DW'(l)};
        datain_ready = 1'b1;
        if (expectFrame) begin
            expQ.push_back({DW'(expR), DW'(expL)});
            startQ.push_back(cyc);
        end
        #1 checkOutput("cbWenFollowsStrobe", cb_wen, 1);
        @(posedge clk); #1;
        datain_ready = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int i = 0; i < maxCycles && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("frameDrained", expQ.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dataOut"}, longint'(data_out), 0);
        checkOutput({tag, "_ready"}, dataout_ready, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
        checkOutput({tag, "_waddr"}, cb_waddr, 0);
        checkOutput({tag, "_raddr"}, cb_raddr, 0);
        checkOutput({tag, "_coefAddr"}, coef_addr, 0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearMem = 1'b1;
        repeat (2) @(posedge clk);
        #1 clearMem = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fb;
        setCoefs(0, 1'b1, 0);
        setCoefs(1, 1'b1, 0);
        #2 reset = 1'b0;
        clearMem = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkResetState("por");
        clearMem = 1'b0;
        @(negedge clk) reset = 1'b1;

        $display("[TB] impulse response");
        applyStimulus(100, -5, 1'b1, 100, -5);
        waitDrain(60);
        checkOutput("holdCh0", lane(data_out, 0), 100);

        $display("[TB] ramp with all-ones taps and pointer wrap");
        doReset();
        setCoefs(0, 1'b0, 1);
        setCoefs(1, 1'b0, 1);
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(3, -2, 1'b1, 3 * ((n < 16) ? n : 16), -2 * ((n < 16) ? n : 16));
            waitDrain(60);
            if (n == 16) checkOutput("waddrWrap", cb_waddr, 0);
        end
        checkOutput("waddrAfter20", cb_waddr, 4);

        $display("[TB] shared coefficient set");
        doReset();
        setCoefs(0, 1'b0, 1);
        setCoefs(1, 1'b0, 7);
        coef_shared = 1'b1;
        badCoefCh = 0;
        sharedWatch = 1'b1;
        applyStimulus(4, -3, 1'b1, 4, -3);
        waitDrain(60);
        sharedWatch = 1'b0;
        checkOutput("coefChStaysZero", badCoefCh, 0);
        coef_shared = 1'b0;
        applyStimulus(0, 0, 1'b1, 4, -21);
        waitDrain(60);

        $display("[TB] overrun");
        doReset();
        setCoefs(0, 1'b1, 0);
        setCoefs(1, 1'b1, 0);
        fb = frames;
        applyStimulus(50, -7, 1'b1, 50, -7);
        repeat (3) @(posedge clk);
        applyStimulus(77, 88, 1'b0, 0, 0);
        checkOutput("overrunSet", overrun, 1);
        checkOutput("busyDuringOverrun", busy, 1);
        waitDrain(60);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("singleReadyPulse", frames - fb, 1);
        checkOutput("overrunSticky", overrun, 1);
        checkOutput("waddrAfterOverrun", cb_waddr, 2);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(11, 12, 1'b0, 0, 0);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1 checkResetState("midFrame");
        @(negedge clk) reset = 1'b1;
        applyStimulus(9, -4, 1'b1, 9, -4);
        waitDrain(60);

        $display("[TB] output range handling");
        doReset();
        setCoefs(0, 1'b0, 131071);
        setCoefs(1, 1'b0, 131071);
        for (int n = 1; n <= 16; n++) begin
            applyStimulus(131071, -131071, 1'b1, SAT ? 131071 : n, SAT ? -131072 : -n);
            waitDrain(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/psdifir_mc_engine.md
Name: psdifir_mc_engine

Overview:
Parametrised multi-channel FIR engine; successor to the single-channel 8-lane FIR datapath.
- Time-multiplexes one NLANES-wide MAC pipeline across NCH audio channels.
- Drives external circular-buffer and coefficient RAMs (1-cycle read latency), owns the write pointer, and produces all channel outputs with a single ready pulse.
- Sits between the audio codec interface and the coefficient/sample RAMs in the top level.

Parameters:
NCH, 2, number of channels (1..8)
NLANES, 8, taps processed per cycle (power of 2)
NTAPS, 2048, filter length and circular-buffer depth per channel (power of 2, multiple of NLANES)
DW, 18, sample width (signed)
CW, 36, coefficient width (signed)
OUT_SHIFT, 35, right shift applied to the accumulator before output

Ports:
clockext100MHz  in  1  master clock, posedge
reset  in  1  asynchronous, active-low master reset
datain_ready  in  1  one-cycle strobe; all NCH input samples valid
data_in  in  NCH*DW  channel c at bits [c*DW +: DW]
coef_shared  in  1  1 = all channels use the channel-0 coefficient set; sampled at frame start
cb_wen  out  1  circular-buffer write enable (equals datain_ready)
cb_waddr  out  log2(NTAPS)  write pointer, common to all channels
cb_ch  out  log2(NCH) (min 1)  channel select for buffer read
cb_raddr  out  log2(NTAPS)  read base: newest sample of the requested NLANES group
cb_rdata  in  NLANES*DW  NLANES samples, newest at MSB, valid 1 cycle after cb_raddr
coef_ch  out  log2(NCH) (min 1)  coefficient set select
coef_addr  out  log2(NTAPS/NLANES)  coefficient group index
coef_rdata  in  NLANES*CW  NLANES coefficients, h[k*NLANES] at MSB, valid 1 cycle after coef_addr
data_out  out  NCH*DW  filtered outputs, held until the next frame completes
dataout_ready  out  1  one-cycle pulse when all data_out are updated
busy  out  1  high from the frame start until dataout_ready
overrun  out  1  sticky; set when datain_ready arrives while busy

Behaviour:
- Reset (reset=0): all outputs 0, wptr=0, FSM IDLE, accumulators 0, overrun cleared.
- Writes: cb_wen=datain_ready combinationally; cb_waddr=wptr; wptr increments modulo NTAPS on each strobe, in any FSM state.
- FSM states: IDLE, ISSUE, DRAIN, ROUND, DONE.
- IDLE -> ISSUE on datain_ready:
  - Latch base=wptr (the slot being written) and coef_shared.
  - ch=0, k=0; busy=1.
- ISSUE, one group per cycle:
  - cb_raddr = base - k*NLANES (mod NTAPS); coef_addr=k; cb_ch=ch; coef_ch = shared ? 0 : ch.
  - After k=NTAPS/NLANES-1, go to DRAIN.
- Pipeline: read data (+1) -> NLANES registered products, DW+CW bits (+1) -> registered adder tree (+1) -> accumulate.
  - Accumulator width ACCW = DW+CW+log2(NTAPS), signed.
  - Acc is cleared on the first group of each channel.
- DRAIN: wait 3 cycles for the pipeline to empty, then go to ROUND.
- ROUND:
  - y = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, reduced to DW bits (see feature).
  - Write y to data_out slice ch.
  - If ch<NCH-1: ch++, k=0, return to ISSUE. Else go to DONE.
- DONE: dataout_ready=1 for one cycle, busy=0, go to IDLE.
- Latency: strobe to dataout_ready = NCH*(NTAPS/NLANES + 4) + 1 cycles.
- Wrap-around: address subtraction is modulo NTAPS; a group may straddle slot 0. The RAM handles straddling groups; the engine only emits the base address.
- datain_ready while busy:
  - Sample is still written and wptr advances.
  - No new frame is started; overrun is set.
  - Outputs of the running frame are unaffected.
- datain_ready in the DONE cycle: counts as busy (overrun set); the FSM returns to IDLE.
- Reset mid-frame: the frame is aborted immediately and data_out is cleared.
- overrun clears only on reset.

Optional Feature:
Macro PSDIFIR_MC_SAT_EN.
- Defined: ROUND saturates to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: ROUND truncates to the low DW bits (two's-complement wrap).
- Rounding offset is added in both cases.

Decomposition:
- Package psdifir_mc_pkg holds:
  - FSM state enum.
  - clog2-based width constants (AW, GW, ACCW).
  - Pipeline depth constant PIPE_LAT=3.
  - round/saturate function.
- One sub-module, psdifir_mac_lanes: NLANES multipliers plus registered adder tree, fixed 2-cycle latency. The FSM and accumulator stay in the top.

Test Plan:
- NCH=2, NLANES=4, NTAPS=16, OUT_SHIFT=0, h=[1,0..0]; impulse 100 on left, -5 on right -> data_out = {-5,100}, dataout_ready at cycle 2*(4+4)+1=17 after the strobe.
- Same config, h all 1, 20 strobes of constant 3 (spaced >17 cycles) -> outputs ramp 3,6,…,48, then hold 48; cb_waddr wraps 15->0 with correct sums.
- coef_shared=1, channel-1 coefficient set all 7 -> coef_ch stays 0 throughout and both channels use the channel-0 result.
- Second strobe 5 cycles after the first -> overrun=1, busy unaffected, one dataout_ready pulse, wptr advanced by 2.
- With SAT_EN, h all 2^17-1, samples 2^17-1 -> output 131071. Without SAT_EN -> wrapped low 18 bits of the rounded result.
- reset asserted at cycle 6 of a frame -> all outputs 0 asynchronously; next strobe after release yields correct output with no stale accumulation.
